iic_arbiter: RTL and testbench

IIC_ARBITER -- requirements
Module: iic_arbiter

---
 rtl/iic_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_iic_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_arbiter.sv
// iic_arbiter: two-client round-robin front end for a single IIC master.
// Each client posts one transaction (w_r, addr, data_in) into its own slot;
// the arbiter replays it on the master interface and returns read data.
// Optional feature macro IIC_ARB_TIMEOUT_EN adds a watchdog on m_busy that
// aborts a stuck transaction and pulses err; without it err is tied low.
module iic_arbiter #(
  // Default is 22'h30D399 widened to the parameter type.
  parameter int unsigned TIMEOUT = 32'h0030_D399
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_iic_trig,
  input  logic        c0_w_r,
  input  logic [15:0] c0_addr,
  input  logic [7:0]  c0_data_in,
  output logic        c0_busy,
  output logic [7:0]  c0_data_out,
  output logic        c0_byte_over,
  input  logic        c1_iic_trig,
  input  logic        c1_w_r,
  input  logic [15:0] c1_addr,
  input  logic [7:0]  c1_data_in,
  output logic        c1_busy,
  output logic [7:0]  c1_data_out,
  output logic        c1_byte_over,
  output logic        m_iic_trig,
  output logic        m_w_r,
  output logic [15:0] m_addr,
  output logic [7:0]  m_data_in,
  input  logic        m_busy,
  input  logic [7:0]  m_data_out,
  input  logic        m_byte_over,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitHi, StWaitLo} state_e;

  state_e            state_q, state_d;
  logic [1:0]        trig;
  logic [1:0]        accept;
  logic [1:0]        clr;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        slot_w_r_q;
  logic [1:0][15:0]  slot_addr_q;
  logic [1:0][7:0]   slot_data_q;
  logic              grant_q;
  logic              last_q;
  logic              sel;
  logic              finish;
  logic              abort;

  assign trig   = {c1_iic_trig, c0_iic_trig};
  // A trigger only lands in an empty slot; a pending slot ignores it.
  assign accept = trig & ~pend_q;
  assign finish = (state_q == StWaitLo) && !m_busy;
  assign clr[0] = (finish || abort) && !grant_q;
  assign clr[1] = (finish || abort) && grant_q;
  // clr only hits a set bit and accept only a clear one, so a slot can never
  // re-arm in the same cycle it completes.
  assign pend_d = (pend_q & ~clr) | accept;

  // On a tie the client that was not served last wins.
  assign sel = (&pend_q) ? ~last_q : pend_q[1];

  assign c0_busy = pend_q[0];
  assign c1_busy = pend_q[1];

`ifdef IIC_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q;

  assign abort = ((state_q == StWaitHi) || (state_q == StWaitLo)) && !finish &&
                 (cnt_q == TIMEOUT - 32'd1);
  assign err   = err_q;

  // Watchdog count: restarts on every state change, advances while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == StWaitHi) || (state_q == StWaitLo)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Watchdog counter and one-cycle error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= abort;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) state_d = StIssue;
      end
      StIssue: begin
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (abort) begin
          state_d = StIdle;
        end else if (m_busy) begin
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (finish || abort) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: trigger pulse and byte_over routed to the granted client.
  always_comb begin
    m_iic_trig   = (state_q == StIssue);
    c0_byte_over = 1'b0;
    c1_byte_over = 1'b0;
    if ((state_q == StWaitHi) || (state_q == StWaitLo)) begin
      c0_byte_over = m_byte_over && !grant_q;
      c1_byte_over = m_byte_over && grant_q;
    end
  end

  // Client slots and pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      slot_w_r_q  <= '0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (accept[0]) begin
        slot_w_r_q[0]  <= c0_w_r;
        slot_addr_q[0] <= c0_addr;
        slot_data_q[0] <= c0_data_in;
      end
      if (accept[1]) begin
        slot_w_r_q[1]  <= c1_w_r;
        slot_addr_q[1] <= c1_addr;
        slot_data_q[1] <= c1_data_in;
      end
    end
  end

  // Grant selection and master command registers, held until back in idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      m_w_r     <= 1'b1;
      m_addr    <= '0;
      m_data_in <= '0;
    end else begin
      if ((state_q == StIdle) && (|pend_q)) begin
        grant_q   <= sel;
        m_w_r     <= slot_w_r_q[sel];
        m_addr    <= slot_addr_q[sel];
        m_data_in <= slot_data_q[sel];
      end
      if (finish || abort) begin
        last_q <= grant_q;
      end
    end
  end

  // Read data return; writes and aborted transactions leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_data_out <= '0;
      c1_data_out <= '0;
    end else if (finish && !m_w_r) begin
      if (grant_q) begin
        c1_data_out <= m_data_out;
      end else begin
        c0_data_out <= m_data_out;
      end
    end
  end

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter with a simple IIC master model.
module tb_iic_arbiter;

  logic        clk;
  logic        rst;
  logic        c0_iic_trig, c1_iic_trig;
  logic        c0_w_r, c1_w_r;
  logic [15:0] c0_addr, c1_addr;
  logic [7:0]  c0_data_in, c1_data_in;
  logic        c0_busy, c1_busy;
  logic [7:0]  c0_data_out, c1_data_out;
  logic        c0_byte_over, c1_byte_over;
  logic        m_iic_trig;
  logic        m_w_r;
  logic [15:0] m_addr;
  logic [7:0]  m_data_in;
  logic        m_busy;
  logic [7:0]  m_data_out;
  logic        m_byte_over;
  logic        err;

  int          pass_cnt = 0;
  int          tot_cnt = 0;
  bit          model_en = 1'b1;
  logic [7:0]  rd_val = 8'h00;
  logic [15:0] log_q[$];

  iic_arbiter #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .c0_iic_trig  (c0_iic_trig),
    .c0_w_r       (c0_w_r),
    .c0_addr      (c0_addr),
    .c0_data_in   (c0_data_in),
    .c0_busy      (c0_busy),
    .c0_data_out  (c0_data_out),
    .c0_byte_over (c0_byte_over),
    .c1_iic_trig  (c1_iic_trig),
    .c1_w_r       (c1_w_r),
    .c1_addr      (c1_addr),
    .c1_data_in   (c1_data_in),
    .c1_busy      (c1_busy),
    .c1_data_out  (c1_data_out),
    .c1_byte_over (c1_byte_over),
    .m_iic_trig   (m_iic_trig),
    .m_w_r        (m_w_r),
    .m_addr       (m_addr),
    .m_data_in    (m_data_in),
    .m_busy       (m_busy),
    .m_data_out   (m_data_out),
    .m_byte_over  (m_byte_over),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Master model: logs each issued address, raises busy two cycles later for four cycles.
  initial begin
    m_busy     = 1'b0;
    m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (m_iic_trig && model_en) begin
        log_q.push_back(m_addr);
        repeat (2) @(negedge clk);
        m_busy     = 1'b1;
        m_data_out = rd_val;
        repeat (4) @(negedge clk);
        m_busy     = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int client, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((client == 0 && !c0_busy) || (client == 1 && !c1_busy)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_all_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!c0_busy && !c1_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_mbusy(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (m_busy === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tot_cnt++;
    if ({c1_busy, c0_busy, m_iic_trig} !== 3'b000)
      $display("FAIL rst_busy_trig: got %b want 000", {c1_busy, c0_busy, m_iic_trig});
    else pass_cnt++;
    tot_cnt++;
    if ({m_w_r, m_addr, m_data_in} !== {1'b1, 16'h0000, 8'h00})
      $display("FAIL rst_master: got %h want %h", {m_w_r, m_addr, m_data_in},
               {1'b1, 16'h0000, 8'h00});
    else pass_cnt++;
    tot_cnt++;
    if ({c1_data_out, c0_data_out, err} !== 17'h0)
      $display("FAIL rst_data_err: got %h want 0", {c1_data_out, c0_data_out, err});
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    bit ok;
    log_q.delete();
    c0_w_r = 1'b1; c0_addr = 16'h1281; c0_data_in = 8'h04; c0_iic_trig = 1'b1;
    tick();
    c0_iic_trig = 1'b0;
    tot_cnt++;
    if ({c0_busy, m_iic_trig} !== 2'b10)
      $display("FAIL wr_capture: got busy/trig %b want 10", {c0_busy, m_iic_trig});
    else pass_cnt++;
    tick();
    tot_cnt++;
    if (m_iic_trig !== 1'b1) $display("FAIL wr_trig_latency: got %b want 1", m_iic_trig);
    else pass_cnt++;
    tot_cnt++;
    if ({m_w_r, m_addr, m_data_in} !== {1'b1, 16'h1281, 8'h04})
      $display("FAIL wr_cmd: got %h want %h", {m_w_r, m_addr, m_data_in},
               {1'b1, 16'h1281, 8'h04});
    else pass_cnt++;
    tick();
    tot_cnt++;
    if (m_iic_trig !== 1'b0) $display("FAIL wr_trig_width: got %b want 0", m_iic_trig);
    else pass_cnt++;
    wait_mbusy(1'b1, 20, ok);
    tot_cnt++;
    if (!ok || {m_addr, m_data_in} !== {16'h1281, 8'h04})
      $display("FAIL wr_cmd_stable: got ok=%b cmd=%h want 1 and 128104", ok, {m_addr, m_data_in});
    else pass_cnt++;
    wait_idle(0, 50, ok);
    tot_cnt++;
    if (!ok) $display("FAIL wr_busy_fall: got busy=%b want 0 within budget", c0_busy);
    else pass_cnt++;
    tot_cnt++;
    if (c0_data_out !== 8'h00) $display("FAIL wr_data_out: got %h want 00", c0_data_out);
    else pass_cnt++;
  endtask

  task automatic test_read();
    bit ok;
    log_q.delete();
    rd_val = 8'h5A;
    c1_w_r = 1'b0; c1_addr = 16'h0003; c1_data_in = 8'hFF; c1_iic_trig = 1'b1;
    tick();
    c1_iic_trig = 1'b0;
    wait_idle(1, 50, ok);
    tot_cnt++;
    if (!ok) $display("FAIL rd_busy_fall: got busy=%b want 0 within budget", c1_busy);
    else pass_cnt++;
    tot_cnt++;
    if ({c1_data_out, c0_data_out} !== {8'h5A, 8'h00})
      $display("FAIL rd_data_out: got c1/c0 %h want 5a00", {c1_data_out, c0_data_out});
    else pass_cnt++;
    tot_cnt++;
    if (log_q.size() != 1 || log_q[0] !== 16'h0003)
      $display("FAIL rd_addr: got %0d issues want 1 at 0003", log_q.size());
    else pass_cnt++;
  endtask

  task automatic test_byte_over();
    bit ok;
    m_byte_over = 1'b1;
    #1;
    tot_cnt++;
    if ({c1_byte_over, c0_byte_over} !== 2'b00)
      $display("FAIL bo_idle: got %b want 00", {c1_byte_over, c0_byte_over});
    else pass_cnt++;
    m_byte_over = 1'b0;
    c1_w_r = 1'b1; c1_addr = 16'h0042; c1_iic_trig = 1'b1;
    tick();
    c1_iic_trig = 1'b0;
    wait_mbusy(1'b1, 20, ok);
    m_byte_over = 1'b1;
    #1;
    tot_cnt++;
    if (!ok || {c1_byte_over, c0_byte_over} !== 2'b10)
      $display("FAIL bo_route: got ok=%b c1/c0 %b want 1 10", ok, {c1_byte_over, c0_byte_over});
    else pass_cnt++;
    tick();
    m_byte_over = 1'b0;
    #1;
    tot_cnt++;
    if ({c1_byte_over, c0_byte_over} !== 2'b00)
      $display("FAIL bo_release: got %b want 00", {c1_byte_over, c0_byte_over});
    else pass_cnt++;
    wait_idle(1, 50, ok);
    tot_cnt++;
    if (!ok) $display("FAIL bo_busy_fall: got busy=%b want 0 within budget", c1_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    c0_w_r = 1'b1; c0_addr = 16'h5555; c0_data_in = 8'h77; c0_iic_trig = 1'b1;
    tick();
    c0_iic_trig = 1'b0;
    wait_mbusy(1'b1, 20, ok);
    // Master is busy, so the arbiter sits in the wait-for-fall state here.
    rst = 1'b1;
    #1;
    tot_cnt++;
    if (!ok || {c0_busy, m_iic_trig, c0_byte_over} !== 3'b000)
      $display("FAIL rstmid_busy: got ok=%b %b want 1 000", ok, {c0_busy, m_iic_trig, c0_byte_over});
    else pass_cnt++;
    tot_cnt++;
    if ({m_w_r, m_addr, m_data_in, c1_data_out} !== {1'b1, 16'h0000, 8'h00, 8'h00})
      $display("FAIL rstmid_regs: got %h want %h", {m_w_r, m_addr, m_data_in, c1_data_out},
               {1'b1, 16'h0000, 8'h00, 8'h00});
    else pass_cnt++;
    #2;
    rst = 1'b0;
    wait_mbusy(1'b0, 20, ok);
    log_q.delete();
    rd_val = 8'h3C;
    c1_w_r = 1'b0; c1_addr = 16'h0007; c1_iic_trig = 1'b1;
    tick();
    c1_iic_trig = 1'b0;
    wait_idle(1, 50, ok);
    tot_cnt++;
    if (!ok || c1_data_out !== 8'h3C || log_q.size() != 1)
      $display("FAIL rstmid_after: got ok=%b data=%h issues=%0d want 1 3c 1",
               ok, c1_data_out, log_q.size());
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [15:0] a0, a1;
    // Right after reset client 0 wins the tie.
    log_q.delete();
    c0_w_r = 1'b1; c0_addr = 16'hA000; c1_w_r = 1'b1; c1_addr = 16'hB001;
    c0_iic_trig = 1'b1; c1_iic_trig = 1'b1;
    tick();
    c0_iic_trig = 1'b0; c1_iic_trig = 1'b0;
    tot_cnt++;
    if ({c1_busy, c0_busy} !== 2'b11)
      $display("FAIL rr_both_captured: got %b want 11", {c1_busy, c0_busy});
    else pass_cnt++;
    wait_all_idle(100, ok);
    a0 = (log_q.size() > 0) ? log_q[0] : 16'hxxxx;
    a1 = (log_q.size() > 1) ? log_q[1] : 16'hxxxx;
    tot_cnt++;
    if (!ok || log_q.size() != 2 || a0 !== 16'hA000 || a1 !== 16'hB001)
      $display("FAIL rr_first_tie: got ok=%b n=%0d %h,%h want 1 2 a000,b001",
               ok, log_q.size(), a0, a1);
    else pass_cnt++;
    // Serve client 0 alone so it becomes last granted; the next tie goes to client 1.
    c0_addr = 16'hA002; c0_iic_trig = 1'b1;
    tick();
    c0_iic_trig = 1'b0;
    wait_idle(0, 50, ok);
    log_q.delete();
    c0_addr = 16'hA004; c1_addr = 16'hB005;
    c0_iic_trig = 1'b1; c1_iic_trig = 1'b1;
    tick();
    c0_iic_trig = 1'b0; c1_iic_trig = 1'b0;
    wait_all_idle(100, ok);
    a0 = (log_q.size() > 0) ? log_q[0] : 16'hxxxx;
    a1 = (log_q.size() > 1) ? log_q[1] : 16'hxxxx;
    tot_cnt++;
    if (!ok || log_q.size() != 2 || a0 !== 16'hB005 || a1 !== 16'hA004)
      $display("FAIL rr_second_tie: got ok=%b n=%0d %h,%h want 1 2 b005,a004",
               ok, log_q.size(), a0, a1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] a1;
    log_q.delete();
    c0_w_r = 1'b1; c0_addr = 16'hC000; c0_iic_trig = 1'b1;
    tick();
    // Held trigger and new address while pending must both be ignored.
    c0_addr = 16'hC001;
    wait_idle(0, 50, ok);
    tot_cnt++;
    if (!ok || log_q.size() != 1 || log_q[0] !== 16'hC000)
      $display("FAIL b2b_first: got ok=%b n=%0d want 1 1 at c000", ok, log_q.size());
    else pass_cnt++;
    tick();
    c0_iic_trig = 1'b0;
    tot_cnt++;
    if (c0_busy !== 1'b1) $display("FAIL b2b_reaccept: got busy=%b want 1", c0_busy);
    else pass_cnt++;
    wait_idle(0, 50, ok);
    a1 = (log_q.size() > 1) ? log_q[1] : 16'hxxxx;
    tot_cnt++;
    if (!ok || log_q.size() != 2 || a1 !== 16'hC001)
      $display("FAIL b2b_second: got ok=%b n=%0d %h want 1 2 c001", ok, log_q.size(), a1);
    else pass_cnt++;
  endtask

`ifdef IIC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    logic [7:0] d0;
    d0 = c0_data_out;
    model_en = 1'b0;
    log_q.delete();
    c0_w_r = 1'b0; c0_addr = 16'hD000; c0_iic_trig = 1'b1;
    tick();  // edge 1: capture
    c0_iic_trig = 1'b0;
    c1_w_r = 1'b1; c1_addr = 16'hD001; c1_iic_trig = 1'b1;
    tick();  // edge 2; wait-high entered at edge 3
    c1_iic_trig = 1'b0;
    repeat (16) tick();  // edge 18
    tot_cnt++;
    if ({err, c0_busy} !== 2'b01) $display("FAIL to_early: got err/busy %b want 01", {err, c0_busy});
    else pass_cnt++;
    tick();  // edge 19 = wait-high entry + 16
    tot_cnt++;
    if ({err, c0_busy, c0_data_out} !== {2'b10, d0})
      $display("FAIL to_abort: got %h want %h", {err, c0_busy, c0_data_out}, {2'b10, d0});
    else pass_cnt++;
    model_en = 1'b1;
    tick();
    tot_cnt++;
    if ({err, m_iic_trig, m_addr} !== {2'b01, 16'hD001})
      $display("FAIL to_next_issue: got %h want %h", {err, m_iic_trig, m_addr}, {2'b01, 16'hD001});
    else pass_cnt++;
    wait_idle(1, 50, ok);
    tot_cnt++;
    if (!ok) $display("FAIL to_next_done: got busy=%b want 0 within budget", c1_busy);
    else pass_cnt++;
  endtask
`else
  task automatic test_no_timeout();
    int errs;
    errs = 0;
    c0_w_r = 1'b1; c0_addr = 16'hE000; c0_iic_trig = 1'b1;
    model_en = 1'b0;
    tick();
    c0_iic_trig = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (err !== 1'b0) errs++;
    end
    tot_cnt++;
    if (errs != 0 || c0_busy !== 1'b1)
      $display("FAIL no_timeout_wait: got err_cycles=%0d busy=%b want 0 1", errs, c0_busy);
    else pass_cnt++;
    model_en = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    c0_iic_trig = 1'b0; c0_w_r = 1'b1; c0_addr = '0; c0_data_in = '0;
    c1_iic_trig = 1'b0; c1_w_r = 1'b1; c1_addr = '0; c1_data_in = '0;
    m_byte_over = 1'b0;
    test_reset();
    test_single_write();
    test_read();
    test_byte_over();
    test_reset_mid();
    test_round_robin();
    test_back_to_back();
`ifdef IIC_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
